booth_mult_seq: RTL and testbench

Sequential radix-2 Booth multiplier for 8-bit signed operands, producing a 16-bit signed product. It sits directly upstream of the 9-bit ripple-carry adder/subtractor in the ALU datapath. Each cycle it drives the adder's operands and its `carry_in` (add/subtract select), then captures the adder's sum. The adder stays instantiated at ALU top level, so it can be shared with the plain add/sub path.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/booth_mult_seq.sv | 100 ++++++++++
 tb/tb_booth_mult_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/adder widths, Booth multiplier state
// encoding and the Booth pair decode constants.
package alu_pkg;

  localparam int W_OP   = 8;
  localparam int W_ADD  = W_OP + 1;
  localparam int N_ITER = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } booth_state_t;

  // Booth pair {Q[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 do nothing.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  function automatic logic pair_active(input logic [1:0] pair);
    return (pair == PAIR_ADD) || (pair == PAIR_SUB);
  endfunction

endpackage

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed.
// The 9-bit adder/subtractor lives outside this block and is reached
// through add_x/add_y/add_sub -> add_sum.
// Optional macro BOOTH_MULT_SKIP_EN: skip ADD cycles whose Booth pair is
// 00/11, giving a data-dependent latency of 8..16 cycles.
module booth_mult_seq
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W_OP-1:0]     op_a,
  input  logic [W_OP-1:0]     op_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*W_OP-1:0]   product,
  output logic [W_ADD-1:0]    add_x,
  output logic [W_ADD-1:0]    add_y,
  output logic                add_sub,
  input  logic [W_ADD-1:0]    add_sum
);

  localparam logic [2:0] CNT_LAST = 3'(N_ITER - 1);

  booth_state_t       state;
  logic [W_ADD-1:0]   acc;
  logic [W_OP-1:0]    mq;
  logic               q_m1;
  logic [W_OP-1:0]    mcand;
  logic [2:0]         cnt;
  logic [1:0]         pair;

  assign pair = {mq[0], q_m1};

  // FSM plus accumulator/multiplier shift register and iteration counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      acc   <= '0;
      mq    <= '0;
      q_m1  <= 1'b0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            mq    <= op_b;
            q_m1  <= 1'b0;
            mcand <= op_a;
            cnt   <= '0;
`ifdef BOOTH_MULT_SKIP_EN
            state <= pair_active({op_b[0], 1'b0}) ? ADD : SHIFT;
`else
            state <= ADD;
`endif
          end
        end
        ADD: begin
          if (pair_active(pair)) begin
            acc <= add_sum;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          acc  <= {acc[W_ADD-1], acc[W_ADD-1:1]};
          mq   <= {acc[0], mq[W_OP-1:1]};
          q_m1 <= mq[0];
          cnt  <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
`ifdef BOOTH_MULT_SKIP_EN
            // After this shift the pair becomes {Q[1], Q[0]}
            state <= pair_active(mq[1:0]) ? ADD : SHIFT;
`else
            state <= ADD;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {acc[W_OP-1:0], mq};
  assign add_x     = acc;
  assign add_y     = {mcand[W_OP-1], mcand};
  assign add_sub   = (state == ADD) && (pair == PAIR_SUB);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: models the external 9-bit adder, checks
// products against a signed multiply and latency against the Booth pair
// count, plus back-pressure, handshake exclusivity and async reset.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [8:0]  add_x;
  logic [8:0]  add_y;
  logic        add_sub;
  logic [8:0]  add_sum;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  cur_a;
  logic [15:0] last_product;
  logic        last_valid;

  booth_mult_seq dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_sub   (add_sub),
    .add_sum   (add_sum)
  );

  // External ripple adder/subtractor, carry_in = add_sub selects subtraction
  assign add_sum = add_sub ? (add_x - add_y) : (add_x + add_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  function automatic int exp_latency(input logic [7:0] b);
`ifdef BOOTH_MULT_SKIP_EN
    int  n;
    logic prev;
    n = 8;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
    return n;
`else
    return 16;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge, check handshake invariants and
  // the product against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_b) begin
      checkOutput("ready_valid_exclusive", 32'(in_ready && out_valid), 0);
      if (in_ready || out_valid) checkOutput("add_sub_outside_add", 32'(add_sub), 0);
      if (!in_ready && !out_valid) checkOutput("add_y_operand", 32'(add_y), 32'({cur_a[7], cur_a}));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          checkOutput("product", 32'(product), 32'(exp_q[0]));
          if (last_valid) checkOutput("product_stable", 32'(product), 32'(last_product));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      last_valid   <= out_valid && !out_ready;
      last_product <= product;
    end else begin
      last_valid <= 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expected, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    cur_a = a;
    exp_q.push_back(expected);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("latency", 32'(n), 32'(exp_latency(b)));
    if (!out_valid) begin
      exp_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", 32'(out_valid), 1);
      checkOutput("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("drain_out_valid", 32'(out_valid), 0);
    checkOutput("drain_in_ready", 32'(in_ready), 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_product"}, 32'(product), 0);
    checkOutput({tag, "_add_x"}, 32'(add_x), 0);
    checkOutput({tag, "_add_y"}, 32'(add_y), 0);
    checkOutput({tag, "_add_sub"}, 32'(add_sub), 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst_b = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    cur_a = '0;
    last_product = '0;
    last_valid = 1'b0;
    #3;
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed products
    applyStimulus(8'd5,    8'd3,    16'h000F, 0);
    applyStimulus(8'h80,   8'h80,   16'h4000, 1);
    applyStimulus(8'hFF,   8'h7F,   16'hFF81, 0);
    applyStimulus(8'h7F,   8'h80,   16'hC080, 5);
    applyStimulus(8'd9,    8'h00,   16'h0000, 0);
    applyStimulus(8'd3,    8'h55,   16'h00FF, 2);
    applyStimulus(8'hFE,   8'h0F,   16'hFFE2, 0);

    // Reset in the middle of a multiplication
    in_valid = 1'b1;
    op_a = 8'h12;
    op_b = 8'h34;
    cur_a = 8'h12;
    exp_q.push_back(16'h03A8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2;
    rst_b = 1'b0;
    #1;
    checkResetValues("async_reset");
    exp_q.delete();
    @(posedge clk); #3;
    rst_b = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("no_valid_after_reset", 32'(out_valid), 0);
    applyStimulus(8'd6, 8'hF9, 16'hFFD6, 0);

    // Random operands with random back-pressure against the signed model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)));
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
